mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multiply/divide unit for the pipelined MIPS core, the next-generation replacement for the in-datapath arithmetic of the single-cycle `mips` top. It owns the HI/LO registers, runs `mult`/`multu`/`div`/`divu` over a configurable number of cycles with a `busy` handshake toward the hazard unit, and services `mthi`/`mtlo`/`mfhi`/`mflo`. It sits beside the ALU in the EX stage.

## Interface
Parameters:
- `WIDTH`, 32: operand width and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for multiply; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for divide; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `start`  in  1  launch the operation selected by `op`.
- `op`  in  2  00 `mult`, 01 `multu`, 10 `div`, 11 `divu`.
- `a`  in  WIDTH  operand rs (dividend).
- `b`  in  WIDTH  operand rt (divisor).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  data for `mthi`/`mtlo`.
- `busy`  out  1  operation in flight.
- `hi`  out  WIDTH  current HI register.
- `lo`  out  WIDTH  current LO register.

## Operation
- Reset (`reset`=0): HI=0, LO=0, `busy`=0, counter=0, latched operands/op cleared; an in-flight operation is discarded with no HI/LO write.
- States: IDLE (`busy`=0), RUN (`busy`=1).
- IDLE, `start`=1: latch `a`, `b`, `op`; load counter with `MULT_CYCLES` (op[1]=0) or `DIV_CYCLES` (op[1]=1); go to RUN. In the same edge, `mthi`/`mtlo` are ignored (start has priority).
- IDLE, `start`=0: `mthi`=1 writes HI←`wdata`; `mtlo`=1 writes LO←`wdata`; both may assert in one cycle, each written.
- RUN: counter decrements each edge; on the edge where counter==1, write result to HI/LO, return to IDLE.
- RUN: `start`, `mthi`, `mtlo` ignored entirely (no latch, no queue); the pipeline stalls them.
- Results, computed from latched operands only:
  - `mult`: signed 2·WIDTH product; HI=upper WIDTH, LO=lower WIDTH.
  - `multu`: same, unsigned.
  - `div`: signed, quotient truncates toward zero → LO; remainder takes sign of dividend → HI. Overflow case a=−2^(WIDTH−1), b=−1: LO=−2^(WIDTH−1), HI=0.
  - `divu`: unsigned quotient → LO, remainder → HI.
  - Divide by zero (b=0, `div` or `divu`): full busy period runs, HI/LO left unchanged.
- `hi`/`lo` are direct register outputs; `mfhi`/`mflo` read them combinationally.

## Timing
- Start sampled at edge E0 → `busy`=1 from E0 through the edge E_N (N=`MULT_CYCLES` or `DIV_CYCLES`): `busy` high exactly N cycles.
- At E_N HI/LO update and `busy` falls together; new values visible in the first cycle `busy`=0.
- Back-to-back: `start` may assert in the first cycle after `busy` falls; that edge launches the next op.
- `mthi`/`mtlo` take effect at the sampling edge; visible next cycle.
- Reset asserted mid-RUN: `busy`, `hi`, `lo` go to 0 asynchronously, without waiting for `clk`; after release, IDLE on next edge.
- Operand inputs may change freely after the start edge; no effect on the result.

## Test plan
- Reset, then `mult` a=−3 (0xFFFFFFFD), b=7 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- `multu` a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE; `start`+`mthi` issued during busy → ignored, results unchanged.
- `div` a=−7, b=2 → `busy` 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); `div` a=0x80000000, b=−1 → LO=0x80000000, HI=0.
- `mthi`=1,`mtlo`=1 with `wdata`=0x12345678 → HI=LO=0x12345678; then `divu` a=5, b=0 → `busy` 10 cycles, HI/LO stay 0x12345678.
- Launch `divu` a=100, b=7, assert `reset`=0 at cycle 4 → `busy`, `hi`, `lo` drop to 0 without a clock edge; after release, no late write occurs; new `divu` gives LO=14, HI=2.
- Re-parametrise `WIDTH`=16, `MULT_CYCLES`=1: `multu` a=0xFFFF, b=0xFFFF → `busy` 1 cycle, HI=0xFFFE, LO=0x0001.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Multiply and divide take a fixed number of busy cycles. The result is
// computed from operands latched at start, so the inputs may change
// during the run without affecting it. mthi/mtlo write HI/LO only while idle.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active-low
  input  logic             start,
  input  logic [1:0]       op,      // 00 mult, 01 multu, 10 div, 11 divu
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Handshake: busy=1 means start/mthi/mtlo are ignored this cycle. The
  // hazard unit must hold them until busy=0. A start seen while busy=0 is
  // accepted on that edge, and it takes priority over mthi/mtlo on the same edge.

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               sign_a, sign_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mag_a, mag_b, den;
  logic [WIDTH-1:0]   uquo, urem, quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               div_by_zero;

  // Result datapath: one sign-extended multiplier for both multiplies, and a
  // magnitude divider with sign fix-up. The overflow case -2^(W-1) / -1 falls
  // out as quotient 2^(W-1) (bit pattern -2^(W-1)) and remainder 0.
  always_comb begin
    sign_a      = ~op_q[0] & a_q[WIDTH-1];
    sign_b      = ~op_q[0] & b_q[WIDTH-1];
    prod        = {{WIDTH{sign_a}}, a_q} * {{WIDTH{sign_b}}, b_q};
    mag_a       = sign_a ? -a_q : a_q;
    mag_b       = sign_b ? -b_q : b_q;
    div_by_zero = (b_q == '0);
    den         = div_by_zero ? WIDTH'(1) : mag_b;
    uquo        = mag_a / den;
    urem        = mag_a % den;
    quo         = (sign_a ^ sign_b) ? -uquo : uquo;
    rem         = sign_a ? -urem : urem;
    if (op_q[1]) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Next-state logic: accept start or mthi/mtlo in IDLE; count down in RUN
  // and commit the result on the last busy edge (skipped on divide by zero).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = op[1] ? DIV_LOAD : MULT_LOAD;
          state_d = S_RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (!(op_q[1] && div_by_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // busy is the FSM state bit itself, so it doubles as the state debug view.
  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized and directed checks of mdu_unit against an
// arithmetic reference model. A 32-bit instance is checked through a
// scoreboard. A 16-bit instance with single-cycle multiply gets short
// directed runs.
module tb_mdu_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic         start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy;
  logic [W-1:0] hi, lo;

  // narrow instance signals
  logic        s_start = 1'b0, s_mthi = 1'b0, s_mtlo = 1'b0;
  logic [1:0]  s_op = '0;
  logic [15:0] s_a = '0, s_b = '0, s_wdata = '0;
  logic        s_busy;
  logic [15:0] s_hi, s_lo;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
  );

  mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
    .mthi(s_mthi), .mtlo(s_mtlo), .wdata(s_wdata), .busy(s_busy), .hi(s_hi), .lo(s_lo)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {hi, lo} (each 32 bits, upper bits zero for w<32).
  function automatic logic [63:0] model(input int w, input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] old_hi, input logic [31:0] old_lo);
    longint one, ux, uy, sx, sy, q, r, mask;
    logic [63:0] p, h, l;
    one  = 1;
    mask = (one << w) - 1;
    ux   = longint'({32'b0, x}) & mask;
    uy   = longint'({32'b0, y}) & mask;
    sx   = (ux >= (one << (w - 1))) ? ux - (one << w) : ux;
    sy   = (uy >= (one << (w - 1))) ? uy - (one << w) : uy;
    if (!o[1]) begin
      p = o[0] ? ux * uy : sx * sy;
      h = (p >> w) & mask;
      l = p & mask;
    end else begin
      if (uy == 0) return {old_hi, old_lo};
      if (o[0]) begin q = ux / uy; r = ux % uy; end
      else      begin q = sx / sy; r = sx % sy; end
      h = r & mask;
      l = q & mask;
    end
    return {h[31:0], l[31:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];   // expected {hi, lo} per launched op
  int             len_q[$];   // expected busy cycles per launched op
  logic [W-1:0]   mdl_hi = '0, mdl_lo = '0;   // HI/LO after all queued ops
  logic [W-1:0]   cur_hi = '0, cur_lo = '0;   // HI/LO visible right now

  // Monitor: while busy, HI/LO must hold; when busy falls, pop and compare.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else if (busy) begin
      busy_cnt++;
      check("hold_hilo", {hi, lo}, {cur_hi, cur_lo});
      prev_busy = 1'b1;
    end else if (prev_busy) begin
      prev_busy = 1'b0;
      if (exp_q.size() == 0) begin
        check("spurious_completion", 64'd1, 64'd0);
      end else begin
        logic [2*W-1:0] e;
        int n;
        e = exp_q.pop_front();
        n = len_q.pop_front();
        check("result_hi", {32'b0, hi}, {32'b0, e[2*W-1:W]});
        check("result_lo", {32'b0, lo}, {32'b0, e[W-1:0]});
        check("busy_len", 64'(busy_cnt), 64'(n));
        cur_hi = e[2*W-1:W];
        cur_lo = e[W-1:0];
      end
      busy_cnt = 0;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic wait_idle();
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (busy && k < 100);
    if (busy) check("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic push_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] e;
    e = model(W, o, x, y, mdl_hi, mdl_lo);
    exp_q.push_back(e);
    len_q.push_back(o[1] ? 10 : 5);
    mdl_hi = e[63:32];
    mdl_lo = e[31:0];
  endtask

  // Launch an op; optionally fire start/mthi/mtlo while busy (must be ignored).
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit noisy);
    push_op(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;   // operands free after start
    if (noisy) begin
      start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    end
    wait_idle();
  endtask

  task automatic mt(input bit h, input bit l, input logic [W-1:0] d);
    mthi = h; mtlo = l; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (h) begin mdl_hi = d; cur_hi = d; end
    if (l) begin mdl_lo = d; cur_lo = d; end
    check("mt_hilo", {hi, lo}, {cur_hi, cur_lo});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return W'($urandom_range(0, 20));
      3:       return '0;
      default: return $urandom;
    endcase
  endfunction

  // Narrow instance: directed run with inline checks.
  task automatic issue16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] oh, input logic [15:0] ol);
    logic [63:0] e;
    int n = 0;
    e = model(16, o, {16'b0, x}, {16'b0, y}, {16'b0, oh}, {16'b0, ol});
    s_start = 1'b1; s_op = o; s_a = x; s_b = y;
    @(posedge clk); #1;
    s_start = 1'b0; s_a = 16'($urandom); s_b = 16'($urandom);
    while (s_busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w16_busy_len", 64'(n), o[1] ? 64'd3 : 64'd1);
    check("w16_hi", {48'b0, s_hi}, {48'b0, e[47:32]});
    check("w16_lo", {48'b0, s_lo}, {48'b0, e[15:0]});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // directed cases
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);            // mult -3*7
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);            // multu, noisy while busy
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);            // div -7/2
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);    // div overflow
    mt(1'b1, 1'b1, 32'h1234_5678);
    issue(2'b11, 32'd5, 32'd0, 1'b0);                    // divu by zero
    mt(1'b1, 1'b0, 32'hCAFE_0001);
    mt(1'b0, 1'b1, 32'h0BAD_F00D);
    issue(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0);            // div by zero keeps HI/LO

    // reset in the middle of a divu
    push_op(2'b11, 32'd100, 32'd7);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_busy", {63'b0, busy}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    exp_q.delete(); len_q.delete();
    mdl_hi = '0; mdl_lo = '0; cur_hi = '0; cur_lo = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no_late_write", {hi, lo}, 64'd0);
    check("idle_after_reset", {63'b0, busy}, 64'd0);
    issue(2'b11, 32'd100, 32'd7, 1'b0);                  // divu 100/7

    // randomized ops, back to back, with occasional mthi/mtlo
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        mt(1'($urandom), 1'($urandom), $urandom);
      issue(2'($urandom), pick(), pick(), 1'($urandom_range(0, 3) == 0));
    end

    // narrow instance: single-cycle multiply and short divides
    issue16(2'b01, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0);
    issue16(2'b00, 16'h8000, 16'hFFFF, 16'hFFFE, 16'h0001);
    issue16(2'b10, 16'hFFF9, 16'h0002, 16'h7FFF, 16'h8000);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom); y = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      issue16(2'($urandom), x, y, s_hi, s_lo);
    end

    // drain: let the monitor see the last completion
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
